ternary_neuron_acc: RTL

Sequential ternary neuron that consumes the 25-input popcount stage. Each accepted beat carries 25 binary activations plus a ternary weight pair (positive mask, negative mask). The block forms popcount(x & wpos) − popcount(x & wneg), accumulates the signed result over NBEATS beats, thresholds the sum to a trit, and presents it on a valid/ready output. It sits between the sensor-side activation buffer and the next printed-NN layer.

---
 rtl/tnn_pkg.sv | 28 ++
 rtl/ternary_dot25.sv | 26 ++
 rtl/ternary_neuron_acc.sv | 119 +++++++++++
 3 files changed

// File: rtl/tnn_pkg.sv
// Shared definitions for the ternary neuron: trit encoding, datapath widths,
// controller states and an exact 25-bit popcount helper.
package tnn_pkg;

    localparam int POP_W   = 5;
    localparam int DELTA_W = 6;

    typedef logic [1:0] trit_t;

    localparam trit_t TRIT_POS  = 2'b01;
    localparam trit_t TRIT_NEG  = 2'b11;
    localparam trit_t TRIT_ZERO = 2'b00;

    typedef enum logic {
        ST_ACCUM,
        ST_HOLD
    } state_e;

    function automatic logic [POP_W-1:0] popcount25(input logic [24:0] v);
        logic [POP_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < 25; i++) begin
            cnt = cnt + POP_W'(v[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/ternary_dot25.sv
// Combinational ternary dot product of 25 binary activations against a
// positive/negative weight mask pair; a bit set in both masks contributes 0.
module ternary_dot25
    import tnn_pkg::*;
(
    input  logic [24:0]               x,
    input  logic [24:0]               wpos,
    input  logic [24:0]               wneg,
    output logic signed [DELTA_W-1:0] delta
);

    logic [24:0]      posMask;
    logic [24:0]      negMask;
    logic [POP_W-1:0] popPos;
    logic [POP_W-1:0] popNeg;

    assign posMask = wpos & ~wneg;
    assign negMask = wneg & ~wpos;

    assign popPos = popcount25(x & posMask);
    assign popNeg = popcount25(x & negMask);

    // Zero-extend both counts by one bit so the difference spans -25..+25.
    assign delta = $signed({1'b0, popPos}) - $signed({1'b0, popNeg});

endmodule

// File: rtl/ternary_neuron_acc.sv
// Sequential ternary neuron: accumulates NBEATS ternary dot products, then
// thresholds the sum to a trit and holds it on a valid/ready output.
module ternary_neuron_acc
    import tnn_pkg::*;
#(
    parameter int NBEATS  = 4,
    parameter int ACC_W   = 8,
    parameter int THR_POS = 10,
    parameter int THR_NEG = -10
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [24:0]             in_x,
    input  logic [24:0]             in_wpos,
    input  logic [24:0]             in_wneg,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [1:0]              out_trit,
    output logic signed [ACC_W-1:0] out_sum
);

    localparam int CNT_W = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NBEATS - 1);
    localparam longint ACC_MAX = (64'sd1 <<< (ACC_W - 1)) - 64'sd1;

    if (NBEATS < 1) begin : g_bad_nbeats
        $error("ternary_neuron_acc: NBEATS must be at least 1");
    end
    if (ACC_MAX < 25 * NBEATS) begin : g_bad_accw
        $error("ternary_neuron_acc: ACC_W too narrow for 25*NBEATS");
    end
    if (THR_NEG >= THR_POS) begin : g_bad_thr
        $error("ternary_neuron_acc: THR_NEG must be below THR_POS");
    end

    state_e                   state_q, state_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic signed [ACC_W-1:0]  sum_q, sum_d;
    trit_t                    trit_q, trit_d;

    logic signed [DELTA_W-1:0] delta;
    logic signed [ACC_W-1:0]   deltaExt;
    logic signed [ACC_W-1:0]   accNext;

    ternary_dot25 u_dot (
        .x    (in_x),
        .wpos (in_wpos),
        .wneg (in_wneg),
        .delta(delta)
    );

    assign deltaExt = {{(ACC_W - DELTA_W){delta[DELTA_W-1]}}, delta};
    assign accNext  = acc_q + deltaExt;

    function automatic trit_t threshold(input logic signed [ACC_W-1:0] s);
        if (s >= THR_POS) begin
            return TRIT_POS;
        end else if (s <= THR_NEG) begin
            return TRIT_NEG;
        end
        return TRIT_ZERO;
    endfunction

    // Handshakes depend on state alone, so out_ready never reaches in_ready combinationally.
    assign in_ready  = (state_q == ST_ACCUM);
    assign out_valid = (state_q == ST_HOLD);
    assign out_sum   = sum_q;
    assign out_trit  = trit_q;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        trit_d  = trit_q;
        case (state_q)
            ST_ACCUM: begin
                if (in_valid) begin
                    if (cnt_q == LAST_BEAT) begin
                        sum_d   = accNext;
                        trit_d  = threshold(accNext);
                        acc_d   = '0;
                        cnt_d   = '0;
                        state_d = ST_HOLD;
                    end else begin
                        acc_d = accNext;
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    state_d = ST_ACCUM;
                end
            end
            default: state_d = ST_ACCUM;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_ACCUM;
            acc_q   <= '0;
            cnt_q   <= '0;
            sum_q   <= '0;
            trit_q  <= TRIT_ZERO;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            trit_q  <= trit_d;
        end
    end

endmodule
